// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit: access sizes, FSM states,
// byte-lane geometry and the alignment rule.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam int LANE_W = 2;
    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Illegal size is reported as misaligned so a single test covers both.
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [LANE_W-1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != '0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering: extracts and extends sub-word load data, and merges sub-word
// store data into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [WORD_W-1:0] i_rd_word,
    input  logic [WORD_W-1:0] i_wdata,
    input  logic [LANE_W-1:0] i_lane,
    input  logic [1:0]        i_size,
    input  logic              i_sign_ext,
    output logic [WORD_W-1:0] o_load_data,
    output logic [WORD_W-1:0] o_merged
);

    logic [BYTE_W-1:0] w_byte;
    logic [HALF_W-1:0] w_half;

    assign w_byte = i_rd_word[{i_lane, 3'b000} +: BYTE_W];
    assign w_half = i_rd_word[{i_lane[1], 4'b0000} +: HALF_W];

    always_comb begin
        // NOTE: both outputs get a default before the case so no path leaves them unassigned (no latch).
        o_load_data = i_rd_word;
        o_merged    = i_rd_word;
        case (i_size)
            SZ_BYTE: begin
                o_load_data = {{(WORD_W-BYTE_W){i_sign_ext & w_byte[BYTE_W-1]}}, w_byte};
                o_merged[{i_lane, 3'b000} +: BYTE_W] = i_wdata[BYTE_W-1:0];
            end
            SZ_HALF: begin
                o_load_data = {{(WORD_W-HALF_W){i_sign_ext & w_half[HALF_W-1]}}, w_half};
                o_merged[{i_lane[1], 4'b0000} +: HALF_W] = i_wdata[HALF_W-1:0];
            end
            default: begin
                o_merged = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked data-memory access unit: byte/half/word loads and stores on a single
// 32-bit memory port, sub-word stores done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int AW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   base,
    input  logic [31:0]   offset,
    input  logic [31:0]   wdata,
    input  logic          store,
    input  logic [1:0]    size,
    input  logic          sign_ext,
    output logic          resp_valid,
    output logic [31:0]   resp_data,
    output logic          resp_err,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    lsu_state_e        r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_req_ready;
    logic              r_store;
    logic [1:0]        r_size;
    logic              r_sign_ext;
    logic [LANE_W-1:0] r_lane;
    logic [31:0]       r_wdata;
    logic              r_resp_valid;
    logic [31:0]       r_resp_data;
    logic              r_resp_err;
    logic [AW-1:0]     r_mem_addr;
    logic              r_mem_we;
    logic [31:0]       r_mem_wdata;

    logic [31:0]       w_addr;
    logic [LANE_W-1:0] w_lane;
    logic [AW-1:0]     w_idx;
    logic              w_err;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merged;

    assign w_addr = base + offset;
    assign w_lane = w_addr[LANE_W-1:0];
    assign w_idx  = w_addr[AW+1:2];
    // Any address bit above the attached memory makes the access out of range.
    assign w_err  = lsu_misaligned(size, w_lane) || ((w_addr >> (AW + 2)) != 32'd0);

    lsu_align u_align (
        .i_rd_word   (mem_rdata),
        .i_wdata     (r_wdata),
        .i_lane      (r_lane),
        .i_size      (r_size),
        .i_sign_ext  (r_sign_ext),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b1;
            r_store      <= 1'b0;
            r_size       <= SZ_BYTE;
            r_sign_ext   <= 1'b0;
            r_lane       <= '0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            // NOTE: all state here uses <= so every register sees pre-edge values, whatever the statement order.
            r_resp_valid <= 1'b0;
            r_mem_we     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_store     <= store;
                        r_size      <= size;
                        r_sign_ext  <= sign_ext;
                        r_lane      <= w_lane;
                        r_wdata     <= wdata;
                        if (w_err) begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_data  <= '0;
                        end else begin
                            r_mem_addr <= w_idx;
                            if (store && (size == SZ_WORD)) begin
                                r_state     <= ST_WRITE;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= wdata;
                            end else begin
                                r_state <= ST_READ;
                                r_cnt   <= CW'(MEM_LAT);
                            end
                        end
                    end
                end
                ST_READ: begin
                    // Address has been held MEM_LAT cycles once the counter reaches zero.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_store) begin
                        r_state     <= ST_WRITE;
                        r_mem_we    <= 1'b1;
                        r_mem_wdata <= w_merged;
                    end else begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= 1'b0;
                        r_resp_data  <= w_load_data;
                    end
                end
                ST_WRITE: begin
                    r_state      <= ST_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_err   <= 1'b0;
                    r_resp_data  <= '0;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;
    assign mem_addr   = r_mem_addr;
    assign mem_we     = r_mem_we;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised, handshaked data-memory access unit for the ex stage.
- Computes the byte address base+offset and supports byte, halfword and word loads and stores.
- Loads can be sign- or zero-extended.
- Misaligned or out-of-range accesses are flagged as errors.
- The memory has one 32-bit port with a single write enable and no byte enables, so sub-word stores are done as read-modify-write. The unit drives the DP_mem32x64k-style port.

Parameters:
AW, 16, word-address width of the attached memory (2^AW 32-bit words)
MEM_LAT, 1, cycles from mem_addr being presented to mem_rdata valid (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request (high only in IDLE)
base  in  32  base byte address
offset  in  32  offset byte address
wdata  in  32  store data (low byte/half used for sub-word stores)
store  in  1  0 = load, 1 = store
size  in  2  00 byte, 01 half, 10 word, 11 illegal
sign_ext  in  1  1 = sign-extend sub-word loads, 0 = zero-extend
resp_valid  out  1  one-cycle completion pulse
resp_data  out  32  load result (0 for stores and errors)
resp_err  out  1  qualifies resp_valid: access rejected
mem_addr  out  AW  memory word address
mem_we  out  1  memory write enable
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data

Behaviour:
- Clock is clk; reset is rst_n, asynchronous and active-low.
- Reset values: req_ready=1 (state IDLE); resp_valid=0, resp_data=0, resp_err=0, mem_addr=0, mem_we=0, mem_wdata=0.
- Address and lanes:
  - addr = base+offset, 32-bit, wraps modulo 2^32.
  - Word index = addr[AW+1:2]; lane = addr[1:0]; little-endian.
- Error conditions:
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - addr[31:AW+2] != 0.
- Handshake: a request is accepted in a cycle T where req_valid && req_ready. All request fields are latched at T and need not be held afterwards.
- States and transitions:
  - IDLE: on accept, go to RESP if error; to WRITE if word store; otherwise to READ.
  - READ: drive mem_addr for MEM_LAT cycles (down-counter), then sample mem_rdata. A load goes to RESP with the extracted result. A sub-word store merges wdata into the sampled word and goes to WRITE.
  - WRITE: mem_we=1 for exactly one cycle, with mem_addr/mem_wdata stable; then go to RESP.
  - RESP: resp_valid=1 for one cycle, then go to IDLE. There is no response backpressure.
- Latency from accept cycle T (resp_valid high in that cycle):
  - error: T+1
  - word store: T+2
  - load: T+2+MEM_LAT
  - sub-word store: T+3+MEM_LAT
- mem_we is 0 in every state other than WRITE. Error requests never touch memory.
- Load extraction:
  - byte = word[8*lane+7 : 8*lane]
  - half = word[16*addr[1]+15 : 16*addr[1]]
  - Extension selected by sign_ext; word loads are unaffected by sign_ext.
- Store merge: only the addressed byte/half lanes are replaced; all other lanes keep the value read from memory.
- resp_data and resp_err are registered and held until the next RESP. resp_err=1 forces resp_data=0.
- Reset mid-operation: the state returns to IDLE immediately and mem_we drops immediately. No partial write completes and no response is issued.
- A new request cannot be accepted in the RESP cycle (req_ready=0). Back-to-back throughput is one request per latency+1 cycles.

Decomposition:
- lsu_pkg:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state encoding IDLE/READ/WRITE/RESP.
  - Lane helper constants.
- Sub-module lsu_align (combinational): extract(word, lane, size, sign_ext) and merge(old, wdata, lane, size). Instantiated once in the unit.
- Top: FSM, latency counter, request/response registers.

Test Plan:
- Word store then load: store base=0x100, offset=0x4, wdata=0xDEADBEEF, size=10. resp at T+2 with mem_we pulse at word 0x41. Load of the same address returns 0xDEADBEEF at T+3 (MEM_LAT=1).
- Sub-word load extension: memory word 0x41 = 0x80FF7F01. Byte load at addr 0x106, sign_ext=1 -> 0xFFFFFFFF. Byte load at addr 0x106, sign_ext=0 -> 0x000000FF. Half load at addr 0x106, sign_ext=1 -> 0xFFFF80FF.
- Read-modify-write:
  - Memory word = 0x11223344; byte store wdata=0xAA at lane 1.
  - Memory word must become 0x1122AA44 with exactly one mem_we pulse.
  - resp at T+4.
- Errors: each of the following gives resp_err=1 at T+1, resp_data=0, no mem_we:
  - half at addr 0x3
  - word at addr 0x2
  - size=11
  - addr=0x00040000 with AW=16
- Address wrap: base=0xFFFFFFFC, offset=0x8 -> addr 0x4; word load reads word 1 without error.
- Reset mid-RMW: assert rst_n=0 while in READ of a sub-word store. mem_we stays 0, memory is unchanged, no resp_valid, req_ready=1 after reset. Rerun with MEM_LAT=3 to check the counter timing.
